// File: rtl/telemetry_rx.sv
// UART (8N1) receiver and 8-byte packet framer for the e-bike telemetry link.
// Presents battery voltage, average current and torque with valid/error strobes.
module telemetry_rx #(
  parameter int unsigned BAUD_DIV = 2604,
  parameter int unsigned TIMEOUT  = 65535
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic [11:0] batt_v,
  output logic [11:0] avg_curr,
  output logic [11:0] avg_torque,
  output logic        pkt_vld,
  output logic        pkt_err,
  output logic [7:0]  pkt_cnt
);

  localparam int unsigned BW   = $clog2(BAUD_DIV + 1);
  localparam int unsigned GW   = $clog2(TIMEOUT + 1);
  localparam int unsigned HALF = (BAUD_DIV / 2 > 0) ? BAUD_DIV / 2 : 1;
  localparam logic [BW-1:0] DIV_L   = BW'(BAUD_DIV);
  localparam logic [BW-1:0] HALF_L  = BW'(HALF);
  localparam logic [GW-1:0] GAP_END = GW'(TIMEOUT - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {HUNT1, HUNT2, PAYLOAD} fr_state_t;

  logic rx_s1_q, rx_s2_q, rx_prev_q;

  rx_state_t   rx_st_q, rx_st_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        byte_rdy_q, byte_rdy_d;
  logic        stop_ok_q, stop_ok_d;

  fr_state_t   fr_q, fr_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  pay_q [5];
  logic [7:0]  pay_d [5];
  logic [GW-1:0] gap_q, gap_d;
  logic [11:0] batt_q, batt_d, curr_q, curr_d, torq_q, torq_d;
  logic        vld_q, vld_d, err_q, err_d;
  logic [7:0]  cnt_q, cnt_d;

  logic sample;

  // Counter reaching 1 marks the sample point; it reloads instead of passing below 1.
  assign sample = (baud_q == BW'(1));

  always_comb begin
    rx_st_d    = rx_st_q;
    baud_d     = baud_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    byte_rdy_d = 1'b0;
    stop_ok_d  = stop_ok_q;
    case (rx_st_q)
      RX_IDLE: begin
        if (!rx_s2_q && rx_prev_q) begin
          rx_st_d = RX_START;
          baud_d  = HALF_L;
        end
      end
      RX_START: begin
        if (sample) begin
          if (!rx_s2_q) begin
            rx_st_d = RX_DATA;
            baud_d  = DIV_L;
            bit_d   = '0;
          end else begin
            rx_st_d = RX_IDLE;
          end
        end else if (baud_q > BW'(1)) begin
          baud_d = baud_q - BW'(1);
        end
      end
      RX_DATA: begin
        if (sample) begin
          shift_d = {rx_s2_q, shift_q[7:1]};
          baud_d  = DIV_L;
          if (bit_q == 3'd7) rx_st_d = RX_STOP;
          else               bit_d   = bit_q + 3'd1;
        end else if (baud_q > BW'(1)) begin
          baud_d = baud_q - BW'(1);
        end
      end
      RX_STOP: begin
        if (sample) begin
          byte_rdy_d = 1'b1;
          stop_ok_d  = rx_s2_q;
          rx_st_d    = RX_IDLE;
        end else if (baud_q > BW'(1)) begin
          baud_d = baud_q - BW'(1);
        end
      end
      default: rx_st_d = RX_IDLE;
    endcase
  end

  always_comb begin
    fr_d   = fr_q;
    idx_d  = idx_q;
    pay_d  = pay_q;
    gap_d  = gap_q;
    batt_d = batt_q;
    curr_d = curr_q;
    torq_d = torq_q;
    cnt_d  = cnt_q;
    vld_d  = 1'b0;
    err_d  = 1'b0;
    if (byte_rdy_q) begin
      gap_d = '0;
      if (!stop_ok_q) begin
        err_d = (fr_q != HUNT1);
        fr_d  = HUNT1;
      end else begin
        case (fr_q)
          HUNT1: if (shift_q == 8'hAA) fr_d = HUNT2;
          HUNT2: begin
            if (shift_q == 8'h55) begin
              fr_d  = PAYLOAD;
              idx_d = '0;
            end else if (shift_q != 8'hAA) begin
              fr_d = HUNT1;
            end
          end
          PAYLOAD: begin
            if (idx_q == 3'd5) begin
              // Last payload byte is taken straight from the shifter, so commit is same-cycle.
              fr_d = HUNT1;
              if (pay_q[0][7:4] == 4'h0 && pay_q[2][7:4] == 4'h0 && pay_q[4][7:4] == 4'h0) begin
                batt_d = {pay_q[0][3:0], pay_q[1]};
                curr_d = {pay_q[2][3:0], pay_q[3]};
                torq_d = {pay_q[4][3:0], shift_q};
                cnt_d  = cnt_q + 8'd1;
                vld_d  = 1'b1;
              end else begin
                err_d = 1'b1;
              end
            end else begin
              pay_d[idx_q] = shift_q;
              idx_d        = idx_q + 3'd1;
            end
          end
          default: fr_d = HUNT1;
        endcase
      end
    end else if (fr_q != HUNT1) begin
      if (gap_q >= GAP_END) begin
        fr_d  = HUNT1;
        err_d = 1'b1;
        gap_d = '0;
      end else begin
        gap_d = gap_q + GW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_st_q    <= RX_IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      byte_rdy_q <= 1'b0;
      stop_ok_q  <= 1'b0;
      fr_q       <= HUNT1;
      idx_q      <= '0;
      pay_q      <= '{default: '0};
      gap_q      <= '0;
      batt_q     <= '0;
      curr_q     <= '0;
      torq_q     <= '0;
      vld_q      <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      rx_s1_q    <= RX;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
      rx_st_q    <= rx_st_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      byte_rdy_q <= byte_rdy_d;
      stop_ok_q  <= stop_ok_d;
      fr_q       <= fr_d;
      idx_q      <= idx_d;
      pay_q      <= pay_d;
      gap_q      <= gap_d;
      batt_q     <= batt_d;
      curr_q     <= curr_d;
      torq_q     <= torq_d;
      vld_q      <= vld_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

  assign batt_v     = batt_q;
  assign avg_curr   = curr_q;
  assign avg_torque = torq_q;
  assign pkt_vld    = vld_q;
  assign pkt_err    = err_q;
  assign pkt_cnt    = cnt_q;

endmodule

// File: tb/tb_telemetry_rx.sv
// Bench for telemetry_rx: UART transmitter model, queue-based packet reference model.
// A second, fast-baud instance runs the 256-packet counter wrap in parallel.
module tb_telemetry_rx;

  localparam int unsigned DIV_M = 16;
  localparam int unsigned TO_M  = 400;
  localparam int unsigned DIV_W = 3;
  localparam int unsigned TO_W  = 100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n_m, rx_m, rst_n_w, rx_w;
  logic [11:0] batt_m, curr_m, torq_m, batt_w, curr_w, torq_w;
  logic        vld_m, err_m, vld_w, err_w;
  logic [7:0]  cnt_m, cnt_w;

  telemetry_rx #(.BAUD_DIV(DIV_M), .TIMEOUT(TO_M)) u_dut (
    .clk(clk), .rst_n(rst_n_m), .RX(rx_m),
    .batt_v(batt_m), .avg_curr(curr_m), .avg_torque(torq_m),
    .pkt_vld(vld_m), .pkt_err(err_m), .pkt_cnt(cnt_m)
  );

  telemetry_rx #(.BAUD_DIV(DIV_W), .TIMEOUT(TO_W)) u_wrap (
    .clk(clk), .rst_n(rst_n_w), .RX(rx_w),
    .batt_v(batt_w), .avg_curr(curr_w), .avg_torque(torq_w),
    .pkt_vld(vld_w), .pkt_err(err_w), .pkt_cnt(cnt_w)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  int mon_vld_m = 0, mon_err_m = 0, mon_vld_w = 0, mon_err_w = 0;

  always @(negedge clk) begin
    if (vld_m || err_m) check("m_vld_err_exclusive", 32'(vld_m & err_m), 0);
    if (vld_w || err_w) check("w_vld_err_exclusive", 32'(vld_w & err_w), 0);
    if (vld_m === 1'b1) mon_vld_m++;
    if (err_m === 1'b1) mon_err_m++;
    if (vld_w === 1'b1) mon_vld_w++;
    if (err_w === 1'b1) mon_err_w++;
  end

  // Reference model: bytes after an accepted 0xAA accumulate until a full frame of 8.
  logic [7:0]  part [$];
  int          exp_vld = 0, exp_err = 0;
  logic [11:0] e_batt = '0, e_curr = '0, e_torq = '0;
  logic [7:0]  e_cnt = '0;
  logic [7:0]  pk [8];

  function automatic void model_byte(input logic [7:0] b, input bit ok);
    logic [7:0] p2, p4, p6;
    if (!ok) begin
      if (part.size() != 0) exp_err++;
      part.delete();
      return;
    end
    if (part.size() == 0) begin
      if (b == 8'hAA) part.push_back(b);
    end else if (part.size() == 1) begin
      if (b == 8'h55) part.push_back(b);
      else if (b != 8'hAA) part.delete();
    end else begin
      part.push_back(b);
      if (part.size() == 8) begin
        p2 = part[2];
        p4 = part[4];
        p6 = part[6];
        if (p2[7:4] == 4'h0 && p4[7:4] == 4'h0 && p6[7:4] == 4'h0) begin
          e_batt = {p2[3:0], part[3]};
          e_curr = {p4[3:0], part[5]};
          e_torq = {p6[3:0], part[7]};
          e_cnt  = e_cnt + 8'd1;
          exp_vld++;
        end else begin
          exp_err++;
        end
        part.delete();
      end
    end
  endfunction

  function automatic void model_idle(input int unsigned n);
    if (n > TO_M && part.size() != 0) begin
      exp_err++;
      part.delete();
    end
  endfunction

  task automatic tx(input bit wr, input logic [7:0] b, input bit stop_ok, input int unsigned div);
    logic [9:0] frame;
    frame = {stop_ok, b, 1'b0};
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      if (wr) rx_w = frame[i];
      else    rx_m = frame[i];
      repeat (div) @(negedge clk);
    end
    if (wr) rx_w = 1'b1;
    else    rx_m = 1'b1;
  endtask

  task automatic check_main(input string tag);
    check({tag, "_vld_count"}, mon_vld_m, exp_vld);
    check({tag, "_err_count"}, mon_err_m, exp_err);
    check({tag, "_batt_v"}, batt_m, e_batt);
    check({tag, "_avg_curr"}, curr_m, e_curr);
    check({tag, "_avg_torque"}, torq_m, e_torq);
    check({tag, "_pkt_cnt"}, cnt_m, e_cnt);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit ok, input string tag);
    tx(1'b0, b, ok, DIV_M);
    repeat (3) @(negedge clk);
    model_byte(b, ok);
    check_main(tag);
  endtask

  task automatic idle_m(input int unsigned n, input string tag);
    repeat (n) @(negedge clk);
    model_idle(n);
    check_main(tag);
  endtask

  // Sends pk[0..n-1] with random inter-byte idle; byte bad_pos carries a 0 stop bit.
  task automatic send_seq(input int n, input int bad_pos, input int unsigned idle_max, input string tag);
    for (int i = 0; i < n; i++) begin
      send_byte(pk[i], (i != bad_pos), tag);
      if (idle_max > 0) repeat ($urandom_range(idle_max)) @(negedge clk);
    end
  endtask

  task automatic fill_pk(input logic [11:0] a, input logic [11:0] c, input logic [11:0] t);
    pk[0] = 8'hAA;            pk[1] = 8'h55;
    pk[2] = {4'h0, a[11:8]};  pk[3] = a[7:0];
    pk[4] = {4'h0, c[11:8]};  pk[5] = c[7:0];
    pk[6] = {4'h0, t[11:8]};  pk[7] = t[7:0];
  endtask

  task automatic main_seq();
    int kind, pos;
    rst_n_m = 1'b0;
    rx_m    = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_batt_v", batt_m, 0);
    check("rst_avg_curr", curr_m, 0);
    check("rst_avg_torque", torq_m, 0);
    check("rst_pkt_cnt", cnt_m, 0);
    check("rst_pkt_vld", vld_m, 0);
    check("rst_pkt_err", err_m, 0);
    rst_n_m = 1'b1;
    repeat (5) @(negedge clk);

    pk = '{8'hAA, 8'h55, 8'h0A, 8'hBC, 8'h01, 8'h23, 8'h0F, 8'hFF};
    send_seq(8, -1, 10, "t1");
    check("t1_batt_const", batt_m, 12'hABC);
    check("t1_curr_const", curr_m, 12'h123);
    check("t1_torq_const", torq_m, 12'hFFF);
    check("t1_cnt_const", cnt_m, 1);
    check("t1_no_err", mon_err_m, 0);

    send_byte(8'h13, 1'b1, "t2");
    send_byte(8'hAA, 1'b1, "t2");
    pk = '{8'hAA, 8'h55, 8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03};
    send_seq(8, -1, 10, "t2");
    check("t2_batt_const", batt_m, 12'h001);
    check("t2_curr_const", curr_m, 12'h002);
    check("t2_torq_const", torq_m, 12'h003);
    check("t2_cnt_const", cnt_m, 2);

    pk = '{8'hAA, 8'h55, 8'h00, 8'h11, 8'h1F, 8'h22, 8'h00, 8'h33};
    send_seq(8, -1, 10, "t3");
    check("t3_err_const", mon_err_m, 1);
    check("t3_batt_hold", batt_m, 12'h001);
    check("t3_cnt_hold", cnt_m, 2);

    pk = '{8'hAA, 8'h55, 8'h00, 8'h44, 8'h00, 8'h55, 8'h00, 8'h66};
    send_seq(6, 5, 10, "t4");
    check("t4_err_const", mon_err_m, 2);
    fill_pk(12'h012, 12'h345, 12'h678);
    send_seq(8, -1, 10, "t4b");
    check("t4_batt_const", batt_m, 12'h012);
    check("t4_cnt_const", cnt_m, 3);

    pk[0] = 8'hAA; pk[1] = 8'h55; pk[2] = 8'h0A;
    send_seq(3, -1, 0, "t5");
    idle_m(500, "t5_timeout");
    check("t5_err_const", mon_err_m, 3);
    fill_pk(12'hDEF, 12'h0F0, 12'h777);
    send_seq(8, -1, 10, "t5b");
    check("t5_torq_const", torq_m, 12'h777);
    check("t5_cnt_const", cnt_m, 4);

    for (int p = 0; p < 20; p++) begin
      kind = $urandom_range(4);
      fill_pk(12'($urandom), 12'($urandom), 12'($urandom));
      case (kind)
        0: send_seq(8, -1, 40, "rnd_ok");
        1: begin
          pos = 2 + 2 * $urandom_range(2);
          pk[pos][7:4] = 4'($urandom_range(15, 1));
          send_seq(8, -1, 40, "rnd_nibble");
        end
        2: send_seq(8, $urandom_range(7), 40, "rnd_stop");
        3: begin
          send_byte(8'($urandom), 1'b1, "rnd_junk");
          send_seq(8, -1, 40, "rnd_junk");
        end
        default: begin
          send_seq($urandom_range(7, 1), -1, 40, "rnd_to");
          idle_m(500, "rnd_to_idle");
        end
      endcase
    end

    pk[0] = 8'hAA; pk[1] = 8'h55; pk[2] = 8'h01;
    send_seq(3, -1, 0, "rst_mid");
    fork
      tx(1'b0, 8'hFF, 1'b1, DIV_M);
      begin
        repeat (70) @(negedge clk);
        rst_n_m = 1'b0;
        repeat (2) @(negedge clk);
        rst_n_m = 1'b1;
      end
    join
    repeat (3) @(negedge clk);
    part.delete();
    e_batt = '0; e_curr = '0; e_torq = '0; e_cnt = '0;
    check_main("rst_mid");
    check("rst_mid_cnt_zero", cnt_m, 0);
    check("rst_mid_batt_zero", batt_m, 0);
    fill_pk(12'h5A5, 12'h0C3, 12'h999);
    send_seq(8, -1, 10, "post_rst");
    check("post_rst_batt_const", batt_m, 12'h5A5);
    check("post_rst_cnt_const", cnt_m, 1);
  endtask

  task automatic wrap_seq();
    logic [11:0] a, c, t;
    logic [7:0]  wcnt;
    wcnt    = '0;
    rst_n_w = 1'b0;
    rx_w    = 1'b1;
    repeat (4) @(negedge clk);
    check("w_rst_pkt_cnt", cnt_w, 0);
    check("w_rst_batt_v", batt_w, 0);
    rst_n_w = 1'b1;
    repeat (3) @(negedge clk);
    for (int n = 1; n <= 257; n++) begin
      a = 12'($urandom); c = 12'($urandom); t = 12'($urandom);
      tx(1'b1, 8'hAA, 1'b1, DIV_W);
      tx(1'b1, 8'h55, 1'b1, DIV_W);
      tx(1'b1, {4'h0, a[11:8]}, 1'b1, DIV_W);
      tx(1'b1, a[7:0], 1'b1, DIV_W);
      tx(1'b1, {4'h0, c[11:8]}, 1'b1, DIV_W);
      tx(1'b1, c[7:0], 1'b1, DIV_W);
      tx(1'b1, {4'h0, t[11:8]}, 1'b1, DIV_W);
      tx(1'b1, t[7:0], 1'b1, DIV_W);
      repeat (3) @(negedge clk);
      wcnt = 8'(n % 256);
      check("wrap_pkt_cnt", cnt_w, wcnt);
      check("wrap_torque", torq_w, t);
      check("wrap_vld_count", mon_vld_w, n);
    end
    check("wrap_err_count", mon_err_w, 0);
  endtask

  initial begin
    fork
      main_seq();
      wrap_seq();
    join
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached before sequences completed");
    $fatal(1, "watchdog");
  end

endmodule
